// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared state encoding and header field layout for the frame config sequencer
package frame_cfg_pkg;
  typedef enum logic [1:0] {HDR, DATA, SETTLE, STROBE} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hFA;
  localparam int SYNC_LO = 24;
  localparam int COL_LO = 16;
  localparam int FRM_LO = 8;
endpackage

// File: rtl/frame_strobe_gen.sv
// frame_strobe_gen: one-hot frame strobe held for StrobeCycles cycles, with done on its final cycle
module frame_strobe_gen #(
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeCycles = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic [$clog2(MaxFramesPerCol)-1:0] frame,
  output logic [MaxFramesPerCol-1:0] strobe,
  output logic done
);
  localparam int NW = $clog2(StrobeCycles + 1);
  logic [NW-1:0] cnt;
  assign done = |strobe && cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      strobe <= '0;
      cnt <= '0;
    end else if (abort || done) begin
      strobe <= '0;
      cnt <= '0;
    end else if (start) begin
      strobe <= MaxFramesPerCol'(1) << frame;
      cnt <= NW'(StrobeCycles - 1);
    end else if (|strobe) begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: decodes frame headers, loads rows onto FrameData, then commits with one FrameStrobe pulse
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows = 16,
  parameter int NumColumns = 16,
  parameter int StrobeCycles = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic [31:0] WriteData,
  input  logic WriteValid,
  output logic WriteReady,
  input  logic Abort,
  input  logic ErrClear,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [NumRows-1:0] RowLoad,
  output logic [$clog2(NumColumns)-1:0] ColSel,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic Busy,
  output logic HdrError,
  output logic [15:0] FramesDone
);
  localparam int CW = $clog2(NumColumns);
  localparam int FW = $clog2(MaxFramesPerCol);
  localparam int RW = $clog2(NumRows);
  state_t state;
  logic [RW-1:0] row;
  logic [FW-1:0] frame;
  logic accept, hdr_ok, strobe_done;
  assign WriteReady = (state == HDR || state == DATA) && !Abort;
  assign accept = WriteValid && WriteReady;
  assign Busy = state != HDR;
  assign hdr_ok = WriteData[SYNC_LO +: 8] == SYNC_BYTE
               && int'(WriteData[COL_LO +: 8]) < NumColumns
               && int'(WriteData[FRM_LO +: 8]) < MaxFramesPerCol;
  frame_strobe_gen #(.MaxFramesPerCol(MaxFramesPerCol), .StrobeCycles(StrobeCycles)) u_strobe (
    .clk(CLK),
    .rst(RST),
    .start(state == SETTLE && !Abort),
    .abort(Abort),
    .frame(frame),
    .strobe(FrameStrobe_O),
    .done(strobe_done)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= HDR;
      row <= '0;
      frame <= '0;
      ColSel <= '0;
      FrameData_O <= '0;
      RowLoad <= '0;
      HdrError <= 1'b0;
      FramesDone <= '0;
    end else begin
      RowLoad <= '0;
      HdrError <= (state == HDR && accept && !hdr_ok) || (HdrError && !ErrClear);
      if (Abort) state <= HDR;
      else case (state)
        HDR: if (accept && hdr_ok) begin
          ColSel <= WriteData[COL_LO +: CW];
          frame <= WriteData[FRM_LO +: FW];
          row <= '0;
          state <= DATA;
        end
        DATA: if (accept) begin
          FrameData_O <= WriteData[FrameBitsPerRow-1:0];
          RowLoad <= NumRows'(1) << row;
          row <= row + 1'b1;
          state <= row == RW'(NumRows - 1) ? SETTLE : DATA;
        end
        SETTLE: state <= STROBE;
        STROBE: if (strobe_done) begin
          FramesDone <= FramesDone + 1'b1;
          state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
endmodule
